// File: rtl/serial_sub_nbit_if.sv
// rtl/serial_sub_nbit_if.sv - start/done handshake and operand/result bundle for serial_sub_nbit
interface serial_sub_nbit_if #(
  parameter int N = 6
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         bout;
  logic         ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_sub_nbit.sv
// rtl/serial_sub_nbit.sv - bit-serial N-bit subtractor, one full-subtractor slice per clock, LSB first
module serial_sub_nbit #(
  parameter int N = 6
) (
  input  logic              clk,
  input  logic              rst,
  serial_sub_nbit_if.slave  bus
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state, state_nxt;
  logic [N-1:0] a_sr, b_sr;
  logic [N-2:0] res_sr;
  logic [N-1:0] res_nxt;
  logic [CW-1:0] cnt;
  logic         brw, brw_nxt, d;
  logic         a_msb, b_msb;
  logic [N-1:0] diff_q;
  logic         bout_q, ovf_q;

  // Single full-subtractor slice on the current LSBs.
  always_comb begin
    d       = a_sr[0] ^ b_sr[0] ^ brw;
    brw_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);
    res_nxt = {d, res_sr};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      brw    <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            brw    <= bus.bin;
            a_msb  <= bus.a[N-1];
            b_msb  <= bus.b[N-1];
            cnt    <= '0;
            res_sr <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_nxt[N-1:1];
          brw    <= brw_nxt;
          cnt    <= cnt + 1'b1;
          // Results are committed only on the final slice so partial sums never show.
          if (cnt == LAST) begin
            diff_q <= res_nxt;
            bout_q <= brw_nxt;
            ovf_q  <= (a_msb ^ b_msb) & (a_msb ^ d);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_sub_nbit.sv
// tb/tb_serial_sub_nbit.sv - randomized and directed bench for serial_sub_nbit against an arithmetic model
module tb_serial_sub_nbit;
  localparam int N = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_sub_nbit_if #(.N(N)) bus();
  serial_sub_nbit #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Model: one op in flight, described by its start/done cycle numbers.
  bit           op_live = 1'b0;
  int           start_cyc = 0;
  int           done_cyc = 0;
  logic [N-1:0] pend_diff, sh_diff;
  logic         pend_bout, pend_ovf, sh_bout, sh_ovf;

  function automatic logic [N+1:0] ref_sub(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic bi);
    logic [N:0] w;
    int sa, sb, r;
    logic o;
    w  = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, bi};
    sa = int'(a);
    sb = int'(b);
    if (a[N-1]) sa = sa - (1 << N);
    if (b[N-1]) sb = sb - (1 << N);
    r  = sa - sb - int'(bi);
    o  = (r < -(1 << (N-1))) || (r > (1 << (N-1)) - 1);
    return {o, w};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    logic [N+1:0] r;
    if (rst) begin
      op_live = 1'b0;
      sh_diff = '0;
      sh_bout = 1'b0;
      sh_ovf  = 1'b0;
    end else begin
      if (op_live && cyc + 1 == done_cyc) begin
        sh_diff = pend_diff;
        sh_bout = pend_bout;
        sh_ovf  = pend_ovf;
      end
      if ((!op_live || cyc > done_cyc) && bus.start === 1'b1) begin
        r = ref_sub(bus.a, bus.b, bus.bin);
        {pend_ovf, pend_bout, pend_diff} = r;
        op_live   = 1'b1;
        start_cyc = cyc;
        done_cyc  = cyc + N + 1;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    logic eb, ed;
    if (chk_en) begin
      eb = op_live && cyc > start_cyc && cyc <= done_cyc;
      ed = op_live && cyc == done_cyc;
      check("cycle", 64'({bus.busy, bus.done, bus.bout, bus.ovf, bus.diff}),
            64'({eb, ed, sh_bout, sh_ovf, sh_diff}));
    end
  end

  task automatic do_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic bi, input logic [N-1:0] ed, input logic eb, input logic eo);
    int t0, k;
    check({name, "_model"}, 64'(ref_sub(a, b, bi)), 64'({eo, eb, ed}));
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.bin = bi;
    t0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = N'($urandom);
    bus.b = N'($urandom);
    bus.bin = 1'($urandom);
    k = 0;
    while (bus.done !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({name, "_latency"}, 64'(cyc - t0), 64'(N + 1));
    check({name, "_result"}, 64'({bus.ovf, bus.bout, bus.diff}), 64'({eo, eb, ed}));
    @(negedge clk);
  endtask

  initial begin
    int t0, nd;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset", 64'({bus.busy, bus.done, bus.bout, bus.ovf, bus.diff}), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    do_op("a20_b7",   6'd20, 6'd7,  1'b0, 6'd13, 1'b0, 1'b0);
    do_op("a7_b20",   6'd7,  6'd20, 1'b0, 6'd51, 1'b1, 1'b0);
    do_op("a31_bm32", 6'd31, 6'd32, 1'b0, 6'd63, 1'b1, 1'b1);
    do_op("a32_b1",   6'd32, 6'd1,  1'b0, 6'd31, 1'b0, 1'b1);
    do_op("zero_bin", 6'd0,  6'd0,  1'b1, 6'd63, 1'b1, 1'b0);
    do_op("zero",     6'd0,  6'd0,  1'b0, 6'd0,  1'b0, 1'b0);

    // Extra start pulses during RUN and DONE must be dropped.
    bus.start = 1'b1;
    bus.a = 6'd50;
    bus.b = 6'd9;
    bus.bin = 1'b1;
    nd = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      bus.start = (i == 3 || i == 7);
      bus.a = N'($urandom);
      if (bus.done === 1'b1) nd++;
    end
    bus.start = 1'b0;
    check("ignored_start_dones", 64'(nd), 64'(1));
    check("ignored_start_diff", 64'({bus.ovf, bus.bout, bus.diff}), 64'({1'b0, 1'b0, 6'd40}));
    @(negedge clk);

    // Start held high: one op per N+2 cycles.
    bus.start = 1'b1;
    nd = 0;
    for (int i = 0; i < 24; i++) begin
      if (bus.done === 1'b1) nd++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("held_start_dones", 64'(nd), 64'(3));
    repeat (2) @(negedge clk);

    // Reset mid-operation aborts without a done pulse.
    bus.start = 1'b1;
    bus.a = 6'd20;
    bus.b = 6'd7;
    bus.bin = 1'b0;
    t0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < t0 + 3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done === 1'b1) nd++;
      @(negedge clk);
    end
    check("rst_abort_dones", 64'(nd), 64'(0));
    check("rst_abort_outs", 64'({bus.busy, bus.bout, bus.ovf, bus.diff}), 64'(0));
    do_op("after_rst", 6'd5, 6'd9, 1'b1, 6'd59, 1'b1, 1'b0);

    for (int i = 0; i < 20000; i++) begin
      rst = ($urandom_range(199) == 0);
      bus.start = ($urandom_range(3) != 0);
      bus.a = N'($urandom);
      bus.b = N'($urandom);
      bus.bin = 1'($urandom);
      @(negedge clk);
    end
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (12) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
